// File: rtl/adc_readout_ctrl.sv
// Serial ADC readout sequencer: shifts DATA_WIDTH bits in over sck/cs_n and emits one AXI-Stream beat per trigger.
// Optional ADC_READOUT_TEST_PATTERN_EN: cfg[3] substitutes a per-beat ramp for the shifted sample.
module adc_readout_ctrl #(
   parameter int unsigned DATA_WIDTH = 18,
   parameter int unsigned SCK_DIV    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        trigger,
   input  logic [31:0] block_len,
   input  logic [31:0] cfg,
   output logic        sck,
   output logic        cs_n,
   input  logic        sdi,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        last,
   output logic        overrun
);
   localparam int unsigned DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, OUTPUT} state_t;

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      div_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic [31:0]           beat_cnt;
   logic [31:0]           sample;
   logic                  enable, clear, handshake, div_wrap, last_beat;
   logic                  accept, drop, shift_done;
   logic                  unused_cfg;

   assign enable    = cfg[0];
   assign clear     = cfg[2];
   assign handshake = m_axis_tvalid && m_axis_tready;
   assign div_wrap  = (div_cnt == DIV_W'(SCK_DIV - 1));
   // Counter may already sit past a shortened block_len; the next beat then closes the block.
   assign last_beat = (block_len != 32'd0) && (beat_cnt >= (block_len - 32'd1));

`ifdef ADC_READOUT_TEST_PATTERN_EN
   logic [31:0] ramp;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)        ramp <= 32'd0;
      else if (clear)     ramp <= 32'd0;
      else if (handshake) ramp <= ramp + 32'd1;
   end

   assign sample     = cfg[3] ? ramp : 32'($signed(shreg));
   assign unused_cfg = ^{cfg[31:4], cfg[1]};
`else
   assign sample     = 32'($signed(shreg));
   assign unused_cfg = ^{cfg[31:3], cfg[1]};
`endif

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state, trigger accept/drop decisions
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      drop       = 1'b0;
      shift_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (trigger && enable) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (trigger && enable) drop = 1'b1;
            if (div_wrap && sck && (bit_cnt == BIT_W'(DATA_WIDTH - 1))) begin
               shift_done = 1'b1;
               state_d    = OUTPUT;
            end
         end
         OUTPUT: begin
            if (handshake) begin
               if (trigger && enable) begin
                  accept  = 1'b1;
                  state_d = SHIFT;
               end else begin
                  state_d = IDLE;
               end
            end else if (trigger && enable) begin
               drop = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Serial interface and stream output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sck           <= 1'b0;
         cs_n          <= 1'b1;
         div_cnt       <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         m_axis_tdata  <= 32'd0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         last          <= 1'b0;
      end else begin
         last <= 1'b0;
         if (accept) begin
            cs_n    <= 1'b0;
            sck     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
         end else if (state_q == SHIFT) begin
            if (div_wrap) begin
               div_cnt <= '0;
               if (!sck) begin
                  sck   <= 1'b1;
                  shreg <= {shreg[DATA_WIDTH-2:0], sdi};
               end else begin
                  sck     <= 1'b0;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end
         if (shift_done) begin
            cs_n          <= 1'b1;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sample;
            m_axis_tlast  <= last_beat;
            last          <= last_beat;
         end else if (handshake) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
         end
      end
   end

   // Beat counter and sticky overrun; clear dominates
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         beat_cnt <= 32'd0;
         overrun  <= 1'b0;
      end else if (clear) begin
         beat_cnt <= 32'd0;
         overrun  <= 1'b0;
      end else begin
         if (drop) overrun <= 1'b1;
         if (handshake) beat_cnt <= m_axis_tlast ? 32'd0 : beat_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_adc_readout_ctrl.sv
// Scoreboard bench for adc_readout_ctrl: stimulus pushes expected beats, a negedge monitor pops on handshake.
module tb_adc_readout_ctrl;
   localparam int DW = 18;

   typedef struct packed {
      logic [31:0] data;
      logic        tl;
   } beat_t;

   logic        clk = 1'b0;
   logic        resetn, trigger, sck, cs_n, sdi;
   logic        tvalid, tready, tlast, last, overrun;
   logic [31:0] block_len, cfg, tdata;
   logic [DW-1:0] adc_word;

   beat_t exp_q[$];
   beat_t got;
   int total = 0, bad = 0;
   int last_cnt = 0, beats_seen = 0, sck_rises = 0, bidx = 0;
   int lat, mark;

   always #5 clk = ~clk;

   adc_readout_ctrl dut (
      .clk(clk), .resetn(resetn), .trigger(trigger), .block_len(block_len), .cfg(cfg),
      .sck(sck), .cs_n(cs_n), .sdi(sdi),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tlast(tlast), .last(last), .overrun(overrun)
   );

   // ADC model: MSB presented at cs_n fall, next bit after each sck fall
   always @(negedge cs_n) bidx = 0;
   always @(negedge sck) bidx = bidx + 1;
   always @(posedge sck) sck_rises = sck_rises + 1;
   assign sdi = (bidx < DW) ? adc_word[DW-1-bidx] : 1'b0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (resetn && tvalid && tready) begin
         beats_seen++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got tdata 0x%08h with empty scoreboard", tdata);
         end else begin
            got = exp_q.pop_front();
            check("beat_tdata", tdata, got.data);
            check("beat_tlast", 32'(tlast), 32'(got.tl));
         end
      end
      if (resetn && last) last_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_trigger;
      @(posedge clk); #1 trigger = 1'b1;
      @(posedge clk); #1 trigger = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] d, input logic tl);
      beat_t b;
      b.data = d;
      b.tl   = tl;
      exp_q.push_back(b);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!tvalid && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic readout(input logic [DW-1:0] w, input logic [31:0] d, input logic tl);
      adc_word = w;
      push_exp(d, tl);
      pulse_trigger();
      tick(100);
   endtask

   task automatic pulse_clear;
      cfg = cfg | 32'h4;
      tick(1);
      cfg = cfg & ~32'h4;
   endtask

   initial begin
      resetn = 1'b0; trigger = 1'b0; tready = 1'b1;
      cfg = 32'd0; block_len = 32'd0; adc_word = '0;
      tick(4);
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tlast", 32'(tlast), 32'd0);
      check("rst_last", 32'(last), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      resetn = 1'b1;
      tick(2);

      // Negative sample, latency and sck edge count
      cfg = 32'h1;
      adc_word = 18'h2A5A5;
      push_exp(32'hFFFEA5A5, 1'b0);
      sck_rises = 0;
      pulse_trigger();
      @(negedge clk);
      check("cs_n_low_T+1", 32'(cs_n), 32'd0);
      wait_valid(lat);
      check("tvalid_latency", lat + 1, 32'd73);
      check("sck_rises", sck_rises, 32'd18);
      check("cs_n_high_at_output", 32'(cs_n), 32'd1);
      check("sck_low_at_output", 32'(sck), 32'd0);
      tick(10);
      readout(18'h15A5A, 32'h00015A5A, 1'b0);

      // Block of four: tlast and last on beat 4 only
      pulse_clear();
      block_len = 32'd4;
      mark = last_cnt;
      readout(18'h00001, 32'h00000001, 1'b0);
      readout(18'h00002, 32'h00000002, 1'b0);
      readout(18'h00003, 32'h00000003, 1'b0);
      readout(18'h20000, 32'hFFFE0000, 1'b1);
      readout(18'h3FFFF, 32'hFFFFFFFF, 1'b0);
      check("last_pulses_block4", last_cnt - mark, 32'd1);

      // Stall: trigger during OUTPUT is dropped, beat held
      pulse_clear();
      block_len = 32'd2;
      tready = 1'b0;
      adc_word = 18'h0ABCD;
      push_exp(32'h0000ABCD, 1'b0);
      pulse_trigger();
      wait_valid(lat);
      check("stall_tvalid_up", 32'(tvalid), 32'd1);
      pulse_trigger();
      @(negedge clk);
      check("overrun_on_output_drop", 32'(overrun), 32'd1);
      tick(5);
      check("stall_tvalid_held", 32'(tvalid), 32'd1);
      check("stall_tdata_held", tdata, 32'h0000ABCD);
      check("stall_tlast_held", 32'(tlast), 32'd0);
      tready = 1'b1;
      tick(2);
      readout(18'h01234, 32'h00001234, 1'b1);
      check("overrun_sticky", 32'(overrun), 32'd1);
      pulse_clear();
      @(negedge clk);
      check("overrun_cleared", 32'(overrun), 32'd0);

      // Trigger during SHIFT is dropped
      adc_word = 18'h00005;
      push_exp(32'h00000005, 1'b0);
      pulse_trigger();
      tick(20);
      pulse_trigger();
      @(negedge clk);
      check("overrun_on_shift_drop", 32'(overrun), 32'd1);
      tick(100);
      pulse_clear();

      // Disabled: triggers ignored, no overrun
      block_len = 32'd0;
      cfg = 32'h0;
      mark = beats_seen;
      pulse_trigger();
      tick(100);
      check("disabled_no_beat", beats_seen - mark, 32'd0);
      check("disabled_no_overrun", 32'(overrun), 32'd0);
      cfg = 32'h1;

      // Reset in the middle of bit 9
      adc_word = 18'h00003;
      pulse_trigger();
      tick(39);
      check("pre_rst_cs_n", 32'(cs_n), 32'd0);
      check("pre_rst_sck", 32'(sck), 32'd1);
      resetn = 1'b0;
      #1;
      check("midrst_cs_n", 32'(cs_n), 32'd1);
      check("midrst_sck", 32'(sck), 32'd0);
      tick(2);
      resetn = 1'b1;
      mark = beats_seen;
      tick(100);
      check("post_rst_no_beat", beats_seen - mark, 32'd0);
      check("post_rst_tvalid", 32'(tvalid), 32'd0);
      readout(18'h00003, 32'h00000003, 1'b0);

`ifdef ADC_READOUT_TEST_PATTERN_EN
      // Ramp replaces shifted data
      cfg = 32'h9;
      pulse_clear();
      readout(18'h3FFFF, 32'h00000000, 1'b0);
      readout(18'h3FFFF, 32'h00000001, 1'b0);
      readout(18'h3FFFF, 32'h00000002, 1'b0);
      cfg = 32'h1;
`endif

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
